seven_seg_scan_driver: RTL
==========================

// Module: seven_seg_scan_driver
// PURPOSE
//   Time-multiplexed scan stage directly upstream of the hex seven-segment decoder.
//   Holds a multi-digit hex value, selects one 4-bit nibble per refresh slot, and drives it on `digit` to the decoder.
//   Drives the matching active-low anode and the decimal point.
//   Adds per-slot blanking (anti-ghosting), per-digit enable masking, and tear-free
//   value updates applied only at frame boundaries.
// PARAMETERS
//   NUM_DIGITS    4        number of display digits; legal range 1..8
//   REFRESH_DIV   100000   clk cycles per digit slot; legal range >= 2
//   BLANK_CYCLES  1000     cycles at start of each slot with all anodes off; legal range 0..REFRESH_DIV-1
// PORTS
//   clk         in   1             system clock; all logic on rising edge
//   rst         in   1             synchronous reset, active-high
//   value       in   4*NUM_DIGITS  hex digits; digit i = value[4*i+3:4*i]
//   digit_en    in   NUM_DIGITS    1 = digit i lit, 0 = digit i always blank
//   dp_in       in   NUM_DIGITS    1 = decimal point of digit i lit
//   load        in   1             1-cycle strobe; captures value/digit_en/dp_in
//   digit       out  4             nibble for the current slot, feeds decoder input
//   an          out  NUM_DIGITS    anode selects, active-low, one-cold or all-ones
//   dp_n        out  1             decimal point, active-low
//   digit_idx   out  3             index of current slot
//   frame_tick  out  1             1-cycle pulse on the cycle the index wraps to 0
// BEHAVIOUR
//   - Registers:
//     - cnt: 0..REFRESH_DIV-1.
//     - idx: 0..NUM_DIGITS-1.
//     - pend_*: pending shadow of value/en/dp, plus the pend_valid flag.
//     - disp_*: displayed copy of value/en/dp.
//   - Reset (rst=1 at edge): cnt=0, idx=0, pend_valid=0, disp_value=0,
//     disp_en=all ones, disp_dp=0.
//     Outputs: an=all ones, digit=0, dp_n=1, digit_idx=0, frame_tick=0.
//     Reset mid-scan aborts the slot and discards any pending load.
//   - Counter: cnt increments every cycle. At cnt==REFRESH_DIV-1:
//     - cnt returns to 0.
//     - idx advances; NUM_DIGITS-1 wraps to 0.
//   - Wrap event: idx==NUM_DIGITS-1 and cnt==REFRESH_DIV-1.
//     - frame_tick=1 on the following cycle, aligned with idx=0, cnt=0.
//   - Slot phases, a function of the new cnt:
//     - BLANK: cnt < BLANK_CYCLES.
//     - DRIVE: otherwise.
//     - With BLANK_CYCLES=0, every cycle is DRIVE.
//   - Outputs are registered and computed from the updated cnt/idx/disp_* on the same edge, so there is no extra lag:
//     - digit = disp_value[4*idx+:4] in both phases (decoder input stays stable).
//     - an = all ones in BLANK, or if disp_en[idx]==0; otherwise ~(1<<idx).
//     - dp_n = ~(disp_dp[idx] & DRIVE & disp_en[idx]).
//     - digit_idx = idx.
//   - Load handshake (no backpressure; load is always accepted):
//     - load=1 and no wrap event: pend_* <= inputs, pend_valid <= 1. A newer load overwrites an older pending one.
//     - Wrap event with pend_valid=1: disp_* <= pend_*, pend_valid <= 0.
//     - load=1 on the wrap-event cycle: disp_* <= inputs directly (latest wins), pend_valid <= 0.
//     - New data therefore appears at the first slot of the next frame.
//     - No digit ever mixes old and new data within a frame.
//   - NUM_DIGITS=1: idx is constant 0; a wrap event occurs every REFRESH_DIV cycles.
//   - Unused upper bits of digit_idx are 0.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 unless noted)
//   1. Reset: hold rst 3 cycles.
//      -> an=4'b1111, digit=0, dp_n=1, frame_tick=0.
//      After release: idx=0 for 8 cycles, then 1, 2, 3, 0; frame_tick pulses every 32 cycles.
//   2. Scan: load value=16'hA3C5, en=4'hF, dp=4'b0100, then wait one full frame.
//      -> Per slot: digit = 5, C, 3, A.
//      -> an = 1111 for 2 cycles, then 1110/1101/1011/0111 for 6 cycles.
//      -> dp_n=0 only in DRIVE of slot 2.
//   3. Tear-free update: load 16'h1234 mid-slot-1, then load 16'h5678 in slot 2.
//      -> digits remain the previous value until the wrap, then show 8, 7, 6, 5; 16'h1234 is never displayed.
//   4. Load on wrap cycle: assert load=1 with value=16'hBEEF exactly at cnt=7, idx=3.
//      -> the next cycle shows idx=0, digit=F, frame_tick=1.
//   5. Masking: en=4'b1010 -> an stays 1111 in slots 0 and 2; dp_n=1 there even with dp=4'hF.
//   6. Reset mid-operation: rst in slot 2 while a load is pending.
//      -> state returns to reset values; the pending value is never displayed.
//      Repeat with BLANK_CYCLES=0: an active from cnt=0.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed hex-digit scanner feeding a seven-segment decoder; outputs are registered with no lag beyond the slot edge.
// load is always accepted; new data is held pending and swapped in only at the frame wrap.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     digit_en,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      load,
   output logic [3:0]                digit,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      dp_n,
   output logic [2:0]                digit_idx,
   output logic                      frame_tick
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]             r_cnt;
   logic [IW-1:0]             r_idx;

   logic [4*NUM_DIGITS-1:0]   r_pend_value;
   logic [NUM_DIGITS-1:0]     r_pend_en;
   logic [NUM_DIGITS-1:0]     r_pend_dp;
   logic                      r_pend_valid;

   logic [4*NUM_DIGITS-1:0]   r_disp_value;
   logic [NUM_DIGITS-1:0]     r_disp_en;
   logic [NUM_DIGITS-1:0]     r_disp_dp;

   logic [3:0]                r_digit;
   logic [NUM_DIGITS-1:0]     r_an;
   logic                      r_dp_n;
   logic [2:0]                r_digit_idx;
   logic                      r_frame_tick;

   logic                      w_cnt_last;
   logic                      w_idx_last;
   logic                      w_wrap;
   logic [CW-1:0]             w_cnt_nxt;
   logic [IW-1:0]             w_idx_nxt;
   logic [2:0]                w_idx_ext;
   logic                      w_blank;
   logic                      w_lit;
   logic [4*NUM_DIGITS-1:0]   w_disp_value_nxt;
   logic [NUM_DIGITS-1:0]     w_disp_en_nxt;
   logic [NUM_DIGITS-1:0]     w_disp_dp_nxt;

   assign w_cnt_last = (r_cnt == CNT_LAST);
   assign w_idx_last = (r_idx == IDX_LAST);
   assign w_wrap     = w_cnt_last & w_idx_last;

   always_comb begin
      w_cnt_nxt = w_cnt_last ? '0 : r_cnt + CW'(1);
      w_idx_nxt = r_idx;
      if (w_cnt_last) begin
         w_idx_nxt = w_idx_last ? '0 : r_idx + IW'(1);
      end
   end

   // A load landing on the wrap cycle bypasses the shadow so the latest data wins.
   always_comb begin
      w_disp_value_nxt = r_disp_value;
      w_disp_en_nxt    = r_disp_en;
      w_disp_dp_nxt    = r_disp_dp;
      if (w_wrap && load) begin
         w_disp_value_nxt = value;
         w_disp_en_nxt    = digit_en;
         w_disp_dp_nxt    = dp_in;
      end else if (w_wrap && r_pend_valid) begin
         w_disp_value_nxt = r_pend_value;
         w_disp_en_nxt    = r_pend_en;
         w_disp_dp_nxt    = r_pend_dp;
      end
   end

   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign w_blank = 1'b0;
      end else begin : g_blank
         assign w_blank = (w_cnt_nxt < CW'(BLANK_CYCLES));
      end
   endgenerate

   assign w_lit = ~w_blank & w_disp_en_nxt[w_idx_nxt];

   always_comb begin
      w_idx_ext            = '0;
      w_idx_ext[IW-1:0]    = w_idx_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_idx        <= '0;
         r_pend_value <= '0;
         r_pend_en    <= '0;
         r_pend_dp    <= '0;
         r_pend_valid <= 1'b0;
         r_disp_value <= '0;
         r_disp_en    <= '1;
         r_disp_dp    <= '0;
         r_digit      <= '0;
         r_an         <= '1;
         r_dp_n       <= 1'b1;
         r_digit_idx  <= '0;
         r_frame_tick <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_idx        <= w_idx_nxt;
         r_disp_value <= w_disp_value_nxt;
         r_disp_en    <= w_disp_en_nxt;
         r_disp_dp    <= w_disp_dp_nxt;

         if (w_wrap) begin
            r_pend_valid <= 1'b0;
         end else if (load) begin
            r_pend_value <= value;
            r_pend_en    <= digit_en;
            r_pend_dp    <= dp_in;
            r_pend_valid <= 1'b1;
         end

         // Digit nibble stays put through blanking so the decoder output is settled when anodes turn on.
         r_digit      <= w_disp_value_nxt[{w_idx_nxt, 2'b00} +: 4];
         r_an         <= w_lit ? ~(NUM_DIGITS'(1) << w_idx_nxt) : '1;
         r_dp_n       <= ~(w_lit & w_disp_dp_nxt[w_idx_nxt]);
         r_digit_idx  <= w_idx_ext;
         r_frame_tick <= w_wrap;
      end
   end

   assign digit      = r_digit;
   assign an         = r_an;
   assign dp_n       = r_dp_n;
   assign digit_idx  = r_digit_idx;
   assign frame_tick = r_frame_tick;

endmodule
